shift_rx: RTL
=============

// Module: shift_rx
// PURPOSE
//  Serial-in/parallel-out receiver: the far end of the serial link driven by the
//  universal shift-register transmitter. Collects WIDTH framed serial bits,
//  LSB-first or MSB-first, and presents the assembled word with a valid/ready
//  handshake. Holds one completed word while the next frame shifts in.
// PARAMETERS
//  WIDTH   4   bits per frame; legal range 2..32
// PORTS
//  clk       in   1      rising-edge clock, sole clock domain
//  reset     in   1      synchronous, active-high reset
//  start     in   1      frame start strobe; captures dir and clears bit count
//  dir       in   1      0 = LSB-first (shift right), 1 = MSB-first (shift left); sampled only with start
//  sin       in   1      serial data bit
//  sin_valid in   1      sin carries a bit this cycle
//  out_ready in   1      consumer accepts q this cycle
//  clr_ovr   in   1      clears sticky overrun
//  q         out  WIDTH  assembled word
//  q_valid   out  1      q holds an unconsumed word
//  busy      out  1      frame in progress (state SHIFT)
//  overrun   out  1      sticky: a completed frame was dropped
// BEHAVIOUR
//  - Reset (synchronous, active-high, highest priority): state=IDLE, shift reg=0, cnt=0,
//    q=0, q_valid=0, busy=0, overrun=0. Reset asserted mid-frame discards the partial frame.
//  - FSM: IDLE, SHIFT. IDLE -> SHIFT on start. SHIFT -> IDLE on the WIDTH-th accepted bit.
//    sin_valid in IDLE without start is ignored.
//  - start in any state: dir_r<=dir, cnt<=0, state SHIFT. Partial bits are discarded.
//    If sin_valid is high in the start cycle, that bit is the first bit of the frame.
//  - Bit accept (SHIFT, or start cycle, with sin_valid=1):
//    dir_r=0: sreg <= {sin, sreg[WIDTH-1:1]}  (first bit ends at q[0])
//    dir_r=1: sreg <= {sreg[WIDTH-2:0], sin}  (first bit ends at q[WIDTH-1]); cnt++.
//  - Frame complete = bit accepted while cnt==WIDTH-1. On the next edge, q is loaded
//    with the post-shift word, q_valid<=1, state IDLE, cnt<=0. Latency: q_valid is high
//    1 cycle after the WIDTH-th bit. Gaps in sin_valid only stretch the frame.
//  - Handshake: transfer occurs when q_valid & out_ready. q is stable while
//    q_valid & !out_ready. After a transfer with no new word, q_valid<=0 and q keeps its value.
//  - Completion while q_valid & out_ready: the new word loads and q_valid stays 1.
//  - Completion while q_valid & !out_ready: the new word is dropped, q unchanged,
//    overrun<=1.
//  - overrun clears only on clr_ovr. If it is set and cleared in the same cycle, set wins.
//  - cnt is $clog2(WIDTH) bits wide. It never exceeds WIDTH-1, so it never wraps.
// STRUCTURE
//  - Shared package shift_pkg holds:
//    - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1
//    - direction codes DIR_LSB=1'b0, DIR_MSB=1'b1
//    - transmitter select codes SEL_HOLD=2'b00, SEL_SHL=2'b01, SEL_SHR=2'b10,
//      SEL_LOAD=2'b11, so both link ends agree on the shift direction
//  - One sub-module: shift_rx_ctr, the bit counter with clear, increment and
//    terminal-count output. FSM, shift register and output buffer stay in shift_rx.
// TESTING (WIDTH=4)
//  1. start dir=0, bits 1,0,1,1 on consecutive cycles
//     -> q=4'b1101, q_valid=1 one cycle after bit 4, busy low.
//  2. start dir=1, bits 1,1,0,0 -> q=4'b1100.
//     Repeat with the same bits and 3 idle cycles between each -> identical q, busy high throughout.
//  3. out_ready=0, frame 4'h5 then frame 4'hA -> q stays 4'h5, overrun=1.
//     Then out_ready=1 -> q_valid=0 next cycle. Then clr_ovr -> overrun=0.
//  4. out_ready=1 held, back-to-back frames 4'h3 and 4'hC, start coinciding with the first bit
//     -> q_valid never drops between words, q=4'h3 then 4'hC.
//  5. dir=0: 2 bits, then start with sin_valid, then 3 more bits (values 0,1,1,0)
//     -> q=4'b0110. The first 2 bits do not appear.
//  6. reset asserted after 2 bits of a frame -> all outputs 0 next cycle.
//     A following frame dir=1, bits 1,0,1,0 -> q=4'b1010.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: encodings shared by both ends of the shift-register serial link
package shift_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;
  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHL  = 2'b01;
  localparam logic [1:0] SEL_SHR  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;
endpackage

// File: rtl/shift_rx_ctr.sv
// shift_rx_ctr: frame bit counter; tc flags the bit that completes a frame
module shift_rx_ctr #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt_q, cnt_d, base;
  // a clear restarts from zero in the same cycle, so a bit arriving with it counts as bit one
  always_comb begin
    base  = clr ? '0 : cnt_q;
    tc    = inc && (base == CW'(WIDTH - 1));
    cnt_d = tc ? '0 : base + CW'(inc);
  end
  // count register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/shift_rx.sv
// shift_rx: serial-in/parallel-out receiver with a one-word valid/ready output buffer
module shift_rx
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic             overrun
);
  state_e state_q, state_d;
  logic dir_q, dir_d, q_valid_q, q_valid_d, overrun_q, overrun_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, q_q, q_d;
  logic accept, eff_dir, done, load;
  shift_rx_ctr #(.WIDTH(WIDTH)) u_ctr (
    .clk  (clk),
    .reset(reset),
    .clr  (start),
    .inc  (accept),
    .tc   (done)
  );
  // start takes effect in its own cycle, so its bit uses the new direction
  always_comb begin
    accept    = sin_valid && (start || state_q == ST_SHIFT);
    eff_dir   = start ? dir : dir_q;
    dir_d     = start ? dir : dir_q;
    sreg_d    = !accept ? sreg_q :
                (eff_dir == DIR_MSB) ? {sreg_q[WIDTH-2:0], sin} : {sin, sreg_q[WIDTH-1:1]};
    state_d   = start ? ST_SHIFT : done ? ST_IDLE : state_q;
    load      = done && (!q_valid_q || out_ready);
    q_d       = load ? sreg_d : q_q;
    q_valid_d = load || (q_valid_q && !out_ready);
    overrun_d = (done && q_valid_q && !out_ready) || (overrun_q && !clr_ovr);
  end
  // FSM, shift register and output buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_LSB;
      sreg_q    <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      sreg_q    <= sreg_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = (state_q == ST_SHIFT);
  assign overrun = overrun_q;
endmodule
